// File: rtl/rreg_read_arbiter_pkg.sv
// Shared constants for the read-back register arbiter: FSM state codes,
// owner codes and mux register indices, plus the strobe decode helper.
package rreg_read_arbiter_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STB  = 2'd1;
  localparam logic [1:0] ST_CAP  = 2'd2;

  // Owner encoding; also the bit position of each requester in req/grant
  localparam logic OWN_TI = 1'b0;
  localparam logic OWN_PI = 1'b1;

  // Mux register indices
  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;
  localparam logic [1:0] SEL_D = 2'd3;

  // Register index to one-hot strobe vector {d,c,b,a}
  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    logic [3:0] v;
    v = 4'b0000;
    case (sel)
      SEL_A: v = 4'b0001;
      SEL_B: v = 4'b0010;
      SEL_C: v = 4'b0100;
      SEL_D: v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/rreg_read_arbiter_rr_pick2.sv
// Two-way picker: bit 0 is TI, bit 1 is Pi. A lone request is granted; on a
// tie the requester that was not served last wins, unless prio_fixed forces
// TI to win every tie. Grant is one-hot or zero.
module rr_pick2
  import rreg_read_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       prio_fixed,
  output logic [1:0] grant
);

  // Pure combinational tie-break
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (prio_fixed || (last == OWN_PI)) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/rreg_read_arbiter.sv
// Read-back mux arbiter between the TI bus read path and the Pi serial read
// path. Grants one requester, strobes the registered 4-way mux for WAIT_CYC
// cycles, captures the mux output into that requester's holding register and
// pulses its ack. Request/ack handshake: req is a level held by the requester
// until it sees its one-cycle ack; data is valid from the ack cycle and stays
// stable until that requester's next ack. Each requester is ignored for the
// cycle its own ack is visible so a req still held there is not re-served.
// Build option: define TI_PRIORITY_EN to make TI win every tie (Pi may starve).
module rreg_read_arbiter
  import rreg_read_arbiter_pkg::*;
#(
  parameter int DW       = 8,
  parameter int WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ti_req,
  input  logic [1:0]    ti_sel,
  output logic          ti_ack,
  output logic [DW-1:0] ti_data,
  input  logic          pi_req,
  input  logic [1:0]    pi_sel,
  output logic          pi_ack,
  output logic [DW-1:0] pi_data,
  output logic          mux_a,
  output logic          mux_b,
  output logic          mux_c,
  output logic          mux_d,
  input  logic [DW-1:0] mux_o,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(WAIT_CYC + 1);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [CW-1:0] r_cnt;
  logic          r_owner;
  logic [1:0]    r_sel;
  logic          r_rr_last;
  logic [3:0]    r_stb;
  logic          r_busy;
  logic          r_ti_ack;
  logic          r_pi_ack;
  logic [DW-1:0] r_ti_data;
  logic [DW-1:0] r_pi_data;

  logic [1:0]    w_elig;
  logic [1:0]    w_grant;
  logic          w_any;
  logic          w_gown;
  logic [1:0]    w_gsel;
  logic          w_prio_fixed;
  logic [3:0]    w_stb_nxt;
  logic          w_busy_nxt;
  logic          w_ti_ack_nxt;
  logic          w_pi_ack_nxt;

`ifdef TI_PRIORITY_EN
  assign w_prio_fixed = 1'b1;
`else
  assign w_prio_fixed = 1'b0;
`endif

  // A requester is masked while its own ack is visible
  assign w_elig = {pi_req & ~r_pi_ack, ti_req & ~r_ti_ack};

  rr_pick2 u_pick (
    .req        (w_elig),
    .last       (r_rr_last),
    .prio_fixed (w_prio_fixed),
    .grant      (w_grant)
  );

  assign w_any  = |w_grant;
  assign w_gown = w_grant[1] ? OWN_PI : OWN_TI;
  assign w_gsel = w_grant[1] ? pi_sel : ti_sel;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; STB lasts until the down-counter reaches its last cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_any) w_next = ST_STB;
      ST_STB:  if (r_cnt == CW'(1)) w_next = ST_CAP;
      ST_CAP:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    w_stb_nxt    = 4'b0000;
    w_busy_nxt   = (w_next != ST_IDLE);
    w_ti_ack_nxt = 1'b0;
    w_pi_ack_nxt = 1'b0;
    if (w_next == ST_STB)
      w_stb_nxt = sel_onehot((r_state == ST_IDLE) ? w_gsel : r_sel);
    if (r_state == ST_CAP) begin
      if (r_owner == OWN_TI) w_ti_ack_nxt = 1'b1;
      else                   w_pi_ack_nxt = 1'b1;
    end
  end

  // Grant bookkeeping: latch owner/sel at grant, count strobe cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner   <= OWN_TI;
      r_sel     <= SEL_A;
      r_cnt     <= '0;
      r_rr_last <= OWN_PI;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_owner   <= w_gown;
            r_sel     <= w_gsel;
            r_cnt     <= CW'(WAIT_CYC);
            r_rr_last <= w_gown;
          end
        end
        ST_STB:  r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // Output registers; CAP samples the mux into the owner's holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stb     <= 4'b0000;
      r_busy    <= 1'b0;
      r_ti_ack  <= 1'b0;
      r_pi_ack  <= 1'b0;
      r_ti_data <= '0;
      r_pi_data <= '0;
    end else begin
      r_stb    <= w_stb_nxt;
      r_busy   <= w_busy_nxt;
      r_ti_ack <= w_ti_ack_nxt;
      r_pi_ack <= w_pi_ack_nxt;
      if (r_state == ST_CAP) begin
        if (r_owner == OWN_TI) r_ti_data <= mux_o;
        else                   r_pi_data <= mux_o;
      end
    end
  end

  assign ti_ack    = r_ti_ack;
  assign pi_ack    = r_pi_ack;
  assign ti_data   = r_ti_data;
  assign pi_data   = r_pi_data;
  assign mux_a     = r_stb[0];
  assign mux_b     = r_stb[1];
  assign mux_c     = r_stb[2];
  assign mux_d     = r_stb[3];
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule
